// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode and FSM
// encodings plus the datapath sizing constants.
package muldiv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ITER_COUNT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // The top opcode bit separates the divide family from the multiply family.
  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign fix-up at the end.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Start,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic                     Flush,
  output logic                     Busy,
  output logic                     ResultValid,
  output logic [DATA_WIDTH-1:0]    MDResult
);
  import muldiv_pkg::*;

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_e         state, state_nxt;
  op_e            op_in, op_q;
  logic [5:0]     count;
  logic [2*W-1:0] acc;
  logic [W-1:0]   b_mag;
  logic           neg_lo, neg_hi;
  logic [W-1:0]   md_result;

  logic           a_signed, b_signed, a_neg, b_neg;
  logic           div_zero, overflow, special, accept, last;
  logic [W-1:0]   a_mag, b_mag_in, special_res;

  logic [W:0]     mul_sum, rem_sh, trial;
  logic [2*W-1:0] acc_step, prod;
  logic [W-1:0]   quo, rem, result_fix;

  assign op_in  = op_e'(Operation);
  assign accept = (state == S_IDLE) && Start && !Flush;
  assign last   = (state == S_BUSY) && (count == 6'(W - 1));

  // Operand decode on the accepting cycle, including the two no-iteration cases.
  always_comb begin
    a_signed = (op_in != OP_MULHU) && (op_in != OP_DIVU) && (op_in != OP_REMU);
    b_signed = a_signed && (op_in != OP_MULHSU);
    a_neg    = a_signed & SrcA[W-1];
    b_neg    = b_signed & SrcB[W-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag_in = b_neg ? -SrcB : SrcB;
    div_zero = is_div(op_in) && (SrcB == '0);
    overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) && (SrcA == MIN_NEG) && (SrcB == '1);
    special  = div_zero | overflow;
    if ((op_in == OP_DIV) || (op_in == OP_DIVU)) special_res = div_zero ? '1 : MIN_NEG;
    else                                         special_res = div_zero ? SrcA : '0;
  end

  // One iteration of the shared accumulator, then the sign fix-up of its outcome.
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh  = acc[2*W-1:W-1];
    trial   = rem_sh - {1'b0, b_mag};
    if (is_div(op_q))
      acc_step = trial[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                          : {trial[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc[W-1:1]};

    prod = neg_lo ? -acc_step : acc_step;
    quo  = neg_lo ? -acc_step[W-1:0] : acc_step[W-1:0];
    rem  = neg_hi ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];

    unique case (op_q)
      OP_MUL:                     result_fix = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_fix = prod[2*W-1:W];
      OP_DIV, OP_DIVU:            result_fix = quo;
      default:                    result_fix = rem;
    endcase
  end

  // NOTE: every combinational output is assigned on every path (defaults first)
  // so no latch is inferred; Flush overrides all other transitions.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_BUSY;
      S_BUSY:  if (last)   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (Flush) state_nxt = S_IDLE;
  end

  // NOTE: state uses non-blocking assignments only; the datapath registers are
  // reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_MUL;
      count     <= '0;
      acc       <= '0;
      b_mag     <= '0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      md_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op_in;
        acc    <= {{W{1'b0}}, a_mag};
        b_mag  <= b_mag_in;
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= a_neg;
        count  <= '0;
        if (special) md_result <= special_res;
      end else if ((state == S_BUSY) && !Flush) begin
        acc   <= acc_step;
        count <= count + 6'd1;
        if (last) md_result <= result_fix;
      end
    end
  end

  assign Busy        = (state == S_BUSY) || accept;
  assign ResultValid = (state == S_DONE);
  assign MDResult    = md_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases, flush/reset
// scenarios and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [2:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic        Flush;
  logic        Busy, ResultValid;
  logic [31:0] MDResult;

  muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Operation(Operation),
    .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush), .Busy(Busy),
    .ResultValid(ResultValid), .MDResult(MDResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] last_result = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Called just after a falling edge with the DUT idle; returns the accepting cycle.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] exp, output int c);
    Start     = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    c         = cyc;
    if (push) begin
      sb_q.push_back('{res: exp, cyc: c + (is_special(op, a, b) ? 1 : 33)});
      last_result = exp;
    end
    #1 check("busy_accept", {31'b0, Busy}, 32'd1);
    @(posedge clk);
    #1;
    Start     = 1'b0;
    SrcA      = $urandom;
    SrcB      = $urandom;
    Operation = 3'($urandom);
  endtask

  // Counts Busy cycles until completion; optionally pokes a Start that must be ignored.
  task automatic wait_done(input bit special, input bit poke);
    int n;
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      Start = poke && (k == 0);
      if (Start) begin
        SrcA      = $urandom;
        SrcB      = $urandom;
        Operation = 3'($urandom);
      end
      if (!Busy) break;
      n++;
    end
    check("busy_cycles", n, special ? 32'd1 : 32'd33);
    @(posedge clk);
    #1 Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit poke);
    int c;
    start_op(op, a, b, 1'b1, exp, c);
    wait_done(is_special(op, a, b), poke);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ResultValid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", {31'b0, ResultValid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", MDResult, e.res);
        check("valid_cycle", cyc, e.cyc);
        check("busy_in_done", {31'b0, Busy}, 32'd0);
      end
    end
  end

  initial begin
    int c;
    rst_n     = 1'b0;
    Start     = 1'b0;
    Flush     = 1'b0;
    Operation = '0;
    SrcA      = '0;
    SrcB      = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, Busy},        32'd0);
    check("reset_valid",  {31'b0, ResultValid}, 32'd0);
    check("reset_result", MDResult,             32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'd100,        32'd7,         32'd14,        1'b1);
    run_op(3'd7, 32'd100,        32'd7,         32'd2,         1'b0);
    run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op(3'd6, 32'd5,          32'd0,         32'd5,         1'b0);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    // Flush in cycle 10 of a DIV, then a new operation accepted in cycle 11.
    start_op(3'd4, 32'd1000, 32'd3, 1'b0, 32'd0, c);
    @(negedge clk);
    while (cyc != c + 10) @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    @(negedge clk);
    check("flush_idle",   {31'b0, Busy}, 32'd0);
    check("flush_result", MDResult,      last_result);
    start_op(3'd0, 32'd12, 32'd12, 1'b1, 32'd144, c);
    wait_done(1'b0, 1'b0);

    // Start together with Flush in IDLE is not accepted.
    Start = 1'b1;
    Flush = 1'b1;
    Operation = 3'd0;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Flush = 1'b0;
    @(negedge clk);
    check("start_flush_ignored", {31'b0, Busy}, 32'd0);

    // Asynchronous reset in cycle 20 of a MUL.
    start_op(3'd0, 32'd123, 32'd456, 1'b0, 32'd0, c);
    @(negedge clk);
    while (cyc != c + 20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy",   {31'b0, Busy},        32'd0);
    check("rst_mid_valid",  {31'b0, ResultValid}, 32'd0);
    check("rst_mid_result", MDResult,             32'd0);
    last_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd7, 32'd77, 32'd10, 32'd7, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      if (op[2] && ($urandom_range(0, 9) == 0)) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op(op, a, b, model(op, a, b), $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
